// File: rtl/hmlf_min_pkg.sv
// Shared defaults, index width and FSM state type for the HMLF sequential min-search scheduler.
package hmlf_min_pkg;

  localparam int W_DEF = 6;
  localparam int N_DEF = 6;
  localparam int IDX_W = $clog2(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/hmlf_min_sched_if.sv
// Handshake bundle between the element-state registers, the min scheduler and its consumer.
// Optional HMLF_MIN_NORM_EN adds the normalized-vector output out_norm.
interface hmlf_min_sched_if
  import hmlf_min_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*W-1:0]       in_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  out_min;
  logic [IW-1:0]        out_idx;
  logic                 busy;
`ifdef HMLF_MIN_NORM_EN
  logic [N*(W+1)-1:0]   out_norm;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_min, out_idx, busy, out_norm
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_min, out_idx, busy, out_norm
  );
`else
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_min, out_idx, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_min, out_idx, busy
  );
`endif

endinterface

// File: rtl/hmlf_min_cmp.sv
// Single signed 2-input comparator shared across all elements of a vector.
module hmlf_min_cmp
  import hmlf_min_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int IW = IDX_W
) (
  input  logic signed [W-1:0] cand_val,
  input  logic [IW-1:0]       cand_idx,
  input  logic signed [W-1:0] cur_val,
  input  logic [IW-1:0]       cur_idx,
  output logic                lt,
  output logic signed [W-1:0] sel_val,
  output logic [IW-1:0]       sel_idx
);

  // Strict less-than keeps the earlier index on ties.
  always_comb begin
    lt = (cand_val < cur_val);
    if (lt) begin
      sel_val = cand_val;
      sel_idx = cand_idx;
    end else begin
      sel_val = cur_val;
      sel_idx = cur_idx;
    end
  end

endmodule

// File: rtl/hmlf_min_sched.sv
// Sequential min-search over N signed elements using one comparator, one element per cycle.
// Define HMLF_MIN_NORM_EN to add out_norm (each element minus the minimum).
module hmlf_min_sched
  import hmlf_min_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  hmlf_min_sched_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e              state_q, state_d;
  logic [N*W-1:0]      vec_q, vec_d;
  logic signed [W-1:0] min_q, min_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;

  logic signed [W-1:0] cand_val;
  logic                cmp_lt;
  logic signed [W-1:0] sel_val;
  logic [IW-1:0]       sel_idx;

  assign cand_val = vec_q[cnt_q*W +: W];

  hmlf_min_cmp #(
    .W  (W),
    .IW (IW)
  ) u_cmp (
    .cand_val (cand_val),
    .cand_idx (cnt_q),
    .cur_val  (min_q),
    .cur_idx  (idx_q),
    .lt       (cmp_lt),
    .sel_val  (sel_val),
    .sel_idx  (sel_idx)
  );

  // Next-state and next-output decode; outputs are precomputed so they leave flops directly.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    min_d       = min_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d      = bus.in_vec;
          min_d      = bus.in_vec[W-1:0];
          idx_d      = '0;
          cnt_d      = IW'(1);
          state_d    = SCAN;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      SCAN: begin
        min_d = sel_val;
        idx_d = sel_idx;
        if (cnt_q == IW'(N - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset that discards any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      min_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      min_q       <= min_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_min   = min_q;
  assign bus.out_idx   = idx_q;
  assign bus.busy      = busy_q;

`ifdef HMLF_MIN_NORM_EN
  // Minimum is never above any element, so the W+1-bit difference is always non-negative.
  for (genvar i = 0; i < N; i++) begin : g_norm
    assign bus.out_norm[i*(W+1) +: (W+1)] =
      {vec_q[i*W+W-1], vec_q[i*W +: W]} - {min_q[W-1], min_q};
  end
`endif

endmodule

// File: tb/tb_hmlf_min_sched.sv
// Directed scoreboard bench for hmlf_min_sched: driver pushes expected min/idx, monitor pops on out_valid rise.
module tb_hmlf_min_sched;

  localparam int W   = 6;
  localparam int N   = 6;
  localparam int IW  = 3;
  localparam int LAT = N - 1;

  typedef struct {
    logic signed [W-1:0] emin;
    logic [IW-1:0]       eidx;
    int                  acc;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  hmlf_min_sched_if #(.W(W), .N(N)) bus ();

  hmlf_min_sched #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks each new result against the scoreboard, and that a consumed result drops.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && prev_ready) begin
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL valid_len: out_valid=%b required 0 after handshake", bus.out_valid);
        end
      end
      if (bus.out_valid && !prev_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: min=%0d idx=%0d with no vector pending",
                   bus.out_min, bus.out_idx);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_min !== e.emin || bus.out_idx !== e.eidx || (cyc - e.acc) != LAT) begin
            n_err++;
            $display("FAIL result: min=%0d idx=%0d lat=%0d required min=%0d idx=%0d lat=%0d",
                     bus.out_min, bus.out_idx, cyc - e.acc, e.emin, e.eidx, LAT);
          end
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
    end
  end

  task automatic send(input int a0, input int a1, input int a2, input int a3, input int a4,
                      input int a5, input int emin, input int eidx, input bit push,
                      input bit keep_valid);
    int a[6];
    int waited;
    exp_t e;
    a = '{a0, a1, a2, a3, a4, a5};
    for (int i = 0; i < N; i++) bus.in_vec[i*W +: W] = W'(a[i]);
    waited = 0;
    while (!bus.in_ready && waited < 60) begin
      step();
      waited++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      bus.in_valid = 1'b1;
      step();
      if (push) begin
        e.emin = W'(emin);
        e.eidx = IW'(eidx);
        e.acc  = cyc;
        exp_q.push_back(e);
      end
      if (!keep_valid) bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!bus.out_valid && w < 60) begin
      step();
      w++;
    end
    if (!bus.out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus.busy) && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) chk("drain_timeout", 0, 1);
    step();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    step();
    step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_min", int'(bus.out_min), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_in_ready_low", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(bus.in_ready), 1);

    bus.out_ready = 1'b1;
    send(2, 0, -3, 7, -3, 5, -3, 2, 1'b1, 1'b0);
    drain();
    send(-32, -32, -32, -32, -32, -32, -32, 0, 1'b1, 1'b0);
    drain();
    send(31, 31, 31, 31, 31, -32, -32, 5, 1'b1, 1'b0);
    drain();

    // Backpressure: hold result while in_valid toggles with a different vector.
    bus.out_ready = 1'b0;
    send(-1, 4, -8, 3, -8, 6, -8, 2, 1'b1, 1'b0);
    wait_valid();
    for (int i = 0; i < N; i++) bus.in_vec[i*W +: W] = 6'b101100;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = ~bus.in_valid;
      step();
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_out_min", int'(bus.out_min), -8);
      chk("bp_out_idx", int'(bus.out_idx), 2);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_busy", int'(bus.busy), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Back-to-back stream with in_valid and out_ready held high.
    send(1, 2, 3, 4, 5, 6, 1, 0, 1'b1, 1'b1);
    send(6, 5, 4, 3, 2, 1, 1, 5, 1'b1, 1'b1);
    send(0, 0, 0, -1, 0, 0, -1, 3, 1'b1, 1'b1);
    send(31, -31, 30, -30, 29, -29, -31, 1, 1'b1, 1'b0);
    drain();

    // Reset while the scan counter sits at 3; the vector must vanish.
    send(9, 8, 7, 6, 5, 4, 4, 5, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_min", int'(bus.out_min), 0);
    chk("mid_rst_out_idx", int'(bus.out_idx), 0);
    chk("mid_rst_in_ready_low", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    send(5, 5, 5, 5, -2, 5, -2, 4, 1'b1, 1'b0);
    drain();

`ifdef HMLF_MIN_NORM_EN
    bus.out_ready = 1'b0;
    send(31, -32, 0, 0, 0, 0, -32, 1, 1'b1, 1'b0);
    wait_valid();
    begin
      int exp_norm[6];
      exp_norm = '{63, 0, 32, 32, 32, 32};
      for (int i = 0; i < N; i++)
        chk("norm", int'(bus.out_norm[i*(W+1) +: (W+1)]), exp_norm[i]);
    end
    bus.out_ready = 1'b1;
    drain();
`endif

    for (int i = 0; i < 10; i++) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
